// File: rtl/add_checker_pkg.sv
// Shared types and default constants for the adder checker.
package add_checker_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 32'd32;
    localparam int unsigned DEFAULT_NUM_TESTS = 32'd64;

    // Run-control states: waiting for start, consuming vectors, finished.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_checker_sat_counter.sv
// 32-bit saturating event counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32'd32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: reset/clear to zero, increment until saturated.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= {W{1'b0}};
        end else if (clear) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/add_checker.sv
// Adder checker: accepts NUM_TESTS vectors {a, b, z} per run and checks
// z == (a + b) mod 2^WIDTH, counting vectors and mismatches.
// Optional feature macro: ADD_CHECKER_FAIL_CAPTURE_EN adds ports that hold
// the first mismatching vector of each run.
module add_checker
    import add_checker_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned NUM_TESTS = DEFAULT_NUM_TESTS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_valid,
    output logic [31:0]      vec_count,
    output logic [31:0]      err_count
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
    ,
    output logic             fail_captured,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_z,
    output logic [WIDTH-1:0] fail_exp
`endif
);

    state_t            state;
    state_t            state_next;
    logic [31:0]       accepted;
    logic              stage_valid;
    logic              stage_err;
    logic              transfer;
    logic              enter_run;
    logic              last_retire;
    logic              mismatch;
    logic [WIDTH-1:0]  expected;

    // Carry-out is intentionally dropped: the sum wraps at 2^WIDTH.
    assign expected    = a + b;
    assign mismatch    = (z != expected);
    assign in_ready    = (state == ST_RUN) && (accepted < NUM_TESTS);
    assign transfer    = in_valid && in_ready;
    // The stage holds the final vector once every vector has been accepted.
    assign last_retire = stage_valid && (accepted == NUM_TESTS);
    assign enter_run   = (state != ST_RUN) && (state_next == ST_RUN);

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = (state == ST_DONE) && (err_count == 32'd0);

    // Next-state logic for the run-control FSM.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_retire) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept counter, one-entry compare stage and the registered error pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            accepted    <= 32'd0;
            stage_valid <= 1'b0;
            stage_err   <= 1'b0;
            err_valid   <= 1'b0;
        end else if (enter_run) begin
            accepted    <= 32'd0;
            stage_valid <= 1'b0;
            stage_err   <= 1'b0;
            err_valid   <= 1'b0;
        end else begin
            if (transfer) begin
                accepted <= accepted + 32'd1;
            end else begin
                accepted <= accepted;
            end
            stage_valid <= transfer;
            stage_err   <= transfer && mismatch;
            err_valid   <= transfer && mismatch;
        end
    end

    sat_counter #(.W(32'd32)) u_vec_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (enter_run),
        .inc     (stage_valid),
        .count   (vec_count)
    );

    sat_counter #(.W(32'd32)) u_err_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (enter_run),
        .inc     (stage_err),
        .count   (err_count)
    );

`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
    // Latch the first mismatching vector of a run; hold until restart/reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fail_captured <= 1'b0;
            fail_a        <= {WIDTH{1'b0}};
            fail_b        <= {WIDTH{1'b0}};
            fail_z        <= {WIDTH{1'b0}};
            fail_exp      <= {WIDTH{1'b0}};
        end else if (enter_run) begin
            fail_captured <= 1'b0;
            fail_a        <= {WIDTH{1'b0}};
            fail_b        <= {WIDTH{1'b0}};
            fail_z        <= {WIDTH{1'b0}};
            fail_exp      <= {WIDTH{1'b0}};
        end else if (transfer && mismatch && !fail_captured) begin
            fail_captured <= 1'b1;
            fail_a        <= a;
            fail_b        <= b;
            fail_z        <= z;
            fail_exp      <= expected;
        end else begin
            fail_captured <= fail_captured;
            fail_a        <= fail_a;
            fail_b        <= fail_b;
            fail_z        <= fail_z;
            fail_exp      <= fail_exp;
        end
    end
`endif

endmodule

// File: tb/tb_add_checker.sv
// Self-checking bench for add_checker: vector tables per run, a scoreboard
// queue for err_valid, and hand-written sequences for reset and restart.
`timescale 1ns/1ps
module tb_add_checker;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [31:0] a, b, z;
    logic        in_ready, busy, done, pass, err_valid;
    logic [31:0] vec_count, err_count;
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
    logic        fail_captured;
    logic [31:0] fail_a, fail_b, fail_z, fail_exp;
`endif

    add_checker #(.WIDTH(32), .NUM_TESTS(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .z         (z),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_valid (err_valid),
        .vec_count (vec_count),
        .err_count (err_count)
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        ,
        .fail_captured (fail_captured),
        .fail_a        (fail_a),
        .fail_b        (fail_b),
        .fail_z        (fail_z),
        .fail_exp      (fail_exp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    vec_t        tbl[256];
    int          n_tbl;
    bit          exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          model_run = 1'b0;
    int          model_acc = 0;
    int          pulses = 0;
    logic [31:0] cap_a, cap_b, cap_z, cap_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pop one scoreboard entry per cycle; with nothing pending err_valid must be low.
    task automatic sb_check();
        bit e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("err_valid", {31'd0, err_valid}, {31'd0, e});
        end else begin
            chk("err_valid_idle", {31'd0, err_valid}, 32'd0);
        end
        if (err_valid === 1'b1) pulses++;
    endtask

    task automatic apply(input vec_t t);
        bit          mr;
        logic [31:0] sum;
        @(negedge clk);
        sb_check();
        mr = model_run && (model_acc < N);
        chk("in_ready", {31'd0, in_ready}, {31'd0, mr});
        in_valid = t.v;
        a = t.a;
        b = t.b;
        z = t.z;
        if (t.v && mr) begin
            sum = t.a + t.b;
            exp_q.push_back(sum != t.z);
            model_acc++;
        end
    endtask

    task automatic apply_table();
        for (int i = 0; i < n_tbl; i++) apply(tbl[i]);
    endtask

    task automatic do_start();
        @(negedge clk);
        sb_check();
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        sb_check();
        start = 1'b0;
        model_run = 1'b1;
        model_acc = 0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        chk("start_vec_clr", vec_count, 32'd0);
        chk("start_err_clr", err_count, 32'd0);
    endtask

    // Bounded wait for done, then check the final run results.
    task automatic finish_run(input int exp_vec, input int exp_err, input bit exp_pass, input int exp_lat);
        int cyc;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            sb_check();
            if (done === 1'b1) break;
        end
        if (exp_lat != 0) chk("done_latency", cyc, exp_lat);
        chk("done", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_ready", {31'd0, in_ready}, 32'd0);
        chk("vec_count", vec_count, exp_vec);
        chk("err_count", err_count, exp_err);
        chk("pass", {31'd0, pass}, {31'd0, exp_pass});
        in_valid = 1'b0;
    endtask

    task automatic fill_clean(input int n);
        vec_t t;
        for (int i = 0; i < n; i++) begin
            t.v = 1'b1;
            t.a = $urandom();
            t.b = $urandom();
            t.z = t.a + t.b;
            tbl[i] = t;
        end
        n_tbl = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        int   cnt;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        a = 32'd0; b = 32'd0; z = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("rst_vec", vec_count, 32'd0);
        chk("rst_err", err_count, 32'd0);
        reset_n = 1'b1;

        // Run A: all vectors correct, including wrap-around sums.
        fill_clean(N);
        tbl[10].a = 32'hFFFF_FFFF; tbl[10].b = 32'h0000_0001; tbl[10].z = 32'h0000_0000;
        tbl[11].a = 32'h8000_0000; tbl[11].b = 32'h8000_0000; tbl[11].z = 32'h0000_0000;
        do_start();
        pulses = 0;
        apply_table();
        finish_run(N, 0, 1'b1, 2);
        chk("runA_pulses", pulses, 32'd0);
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        chk("runA_fail_captured", {31'd0, fail_captured}, 32'd0);
`endif

        // Run B: restart from DONE, single mismatch at vector 5.
        fill_clean(N);
        tbl[5].a = 32'h0000_0001; tbl[5].b = 32'h0000_0002; tbl[5].z = 32'h0000_0004;
        do_start();
        pulses = 0;
        apply_table();
        finish_run(N, 1, 1'b0, 2);
        chk("runB_pulses", pulses, 32'd1);
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        chk("runB_fail_captured", {31'd0, fail_captured}, 32'd1);
        chk("runB_fail_a", fail_a, 32'd1);
        chk("runB_fail_b", fail_b, 32'd2);
        chk("runB_fail_z", fail_z, 32'd4);
        chk("runB_fail_exp", fail_exp, 32'd3);
`endif

        // Run C: random in_valid gaps, mismatches at vectors 3 and 7,
        // in_valid held high well past the last accepted vector.
        n_tbl = 0;
        cnt = 0;
        while (cnt < N) begin
            t.v = ($urandom_range(0, 3) != 0);
            t.a = $urandom();
            t.b = $urandom();
            if (t.v) begin
                t.z = t.a + t.b;
                if (cnt == 3 || cnt == 7) t.z = t.z ^ 32'h0000_0100;
                if (cnt == 3) begin
                    cap_a = t.a; cap_b = t.b; cap_z = t.z; cap_exp = t.a + t.b;
                end
                cnt++;
            end else begin
                t.z = $urandom();
            end
            tbl[n_tbl] = t;
            n_tbl++;
        end
        for (int i = 0; i < 6; i++) begin
            t.v = 1'b1; t.a = $urandom(); t.b = $urandom(); t.z = $urandom();
            tbl[n_tbl] = t;
            n_tbl++;
        end
        do_start();
        pulses = 0;
        apply_table();
        finish_run(N, 2, 1'b0, 0);
        chk("runC_pulses", pulses, 32'd2);
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        chk("runC_fail_a", fail_a, cap_a);
        chk("runC_fail_b", fail_b, cap_b);
        chk("runC_fail_z", fail_z, cap_z);
        chk("runC_fail_exp", fail_exp, cap_exp);
`endif

        // Run D: reset in the middle of a run, then restart from IDLE.
        fill_clean(10);
        tbl[3].z = tbl[3].z + 32'd1;
        do_start();
        apply_table();
        @(negedge clk);
        sb_check();
        reset_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        model_run = 1'b0;
        model_acc = 0;
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_pass", {31'd0, pass}, 32'd0);
        chk("midrst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("midrst_vec", vec_count, 32'd0);
        chk("midrst_err", err_count, 32'd0);
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        chk("midrst_fail_captured", {31'd0, fail_captured}, 32'd0);
`endif
        reset_n = 1'b1;
        // In IDLE a valid vector must not be accepted.
        apply(tbl[0]);
        apply(tbl[1]);
        fill_clean(N);
        do_start();
        for (int i = 0; i < 3; i++) apply(tbl[i]);
        // Start while running is ignored; the counts keep going.
        @(negedge clk);
        sb_check();
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        sb_check();
        start = 1'b0;
        chk("run_start_busy", {31'd0, busy}, 32'd1);
        chk("run_start_vec", vec_count, 32'd3);
        for (int i = 3; i < N; i++) apply(tbl[i]);
        finish_run(N, 0, 1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
